// File: rtl/id_exe_hazard_reg.sv
// ID/EXE pipeline register with load-use hazard detection and bubble insertion.
// Optional load-use bubble counter on stall_cnt_o, enabled by defining ID_EXE_STALL_CNT_EN.
module id_exe_hazard_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic              id_use_rs2_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              id_memtoreg_i,
  input  logic              id_alusrc_i,
  input  logic              id_branch_i,
  input  logic [1:0]        id_aluop_i,
  input  logic [DATA_W-1:0] id_rs1_data_i,
  input  logic [DATA_W-1:0] id_rs2_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [DATA_W-1:0] id_pc_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              exe_valid_o,
  output logic [4:0]        exe_rs1_o,
  output logic [4:0]        exe_rs2_o,
  output logic [4:0]        exe_rd_o,
  output logic              exe_use_rs2_o,
  output logic              exe_regwrite_o,
  output logic              exe_memread_o,
  output logic              exe_memwrite_o,
  output logic              exe_memtoreg_o,
  output logic              exe_alusrc_o,
  output logic              exe_branch_o,
  output logic [1:0]        exe_aluop_o,
  output logic [DATA_W-1:0] exe_rs1_data_o,
  output logic [DATA_W-1:0] exe_rs2_data_o,
  output logic [DATA_W-1:0] exe_imm_o,
  output logic [DATA_W-1:0] exe_pc_o,
  output logic [31:0]       stall_cnt_o
);

  logic              r_vld_p1;
  logic [4:0]        r_rs1_p1, r_rs2_p1, r_rd_p1;
  logic              r_use_rs2_p1, r_regwrite_p1, r_memread_p1, r_memwrite_p1;
  logic              r_memtoreg_p1, r_alusrc_p1, r_branch_p1;
  logic [1:0]        r_aluop_p1;
  logic [DATA_W-1:0] r_rs1_data_p1, r_rs2_data_p1, r_imm_p1, r_pc_p1;

  logic w_hz;
  logic w_bubble;

  // x0 is never a hazard source; rs2 only matters when the instruction reads it.
  assign w_hz = r_vld_p1 & r_memread_p1 & (r_rd_p1 != 5'd0) & id_valid_i &
                ((r_rd_p1 == id_rs1_i) | (id_use_rs2_i & (r_rd_p1 == id_rs2_i)));
  assign stall_o  = w_hz & ~flush_i;
  assign w_bubble = flush_i | w_hz;

  // ID -> EXE boundary: a bubble zeroes everything so forwarding never matches it.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_bubble) begin
      r_vld_p1      <= 1'b0;
      r_rs1_p1      <= '0;
      r_rs2_p1      <= '0;
      r_rd_p1       <= '0;
      r_use_rs2_p1  <= 1'b0;
      r_regwrite_p1 <= 1'b0;
      r_memread_p1  <= 1'b0;
      r_memwrite_p1 <= 1'b0;
      r_memtoreg_p1 <= 1'b0;
      r_alusrc_p1   <= 1'b0;
      r_branch_p1   <= 1'b0;
      r_aluop_p1    <= '0;
      r_rs1_data_p1 <= '0;
      r_rs2_data_p1 <= '0;
      r_imm_p1      <= '0;
      r_pc_p1       <= '0;
    end else begin
      r_vld_p1      <= id_valid_i;
      r_rs1_p1      <= id_rs1_i;
      r_rs2_p1      <= id_rs2_i;
      r_rd_p1       <= id_rd_i;
      r_use_rs2_p1  <= id_use_rs2_i;
      r_regwrite_p1 <= id_regwrite_i;
      r_memread_p1  <= id_memread_i;
      r_memwrite_p1 <= id_memwrite_i;
      r_memtoreg_p1 <= id_memtoreg_i;
      r_alusrc_p1   <= id_alusrc_i;
      r_branch_p1   <= id_branch_i;
      r_aluop_p1    <= id_aluop_i;
      r_rs1_data_p1 <= id_rs1_data_i;
      r_rs2_data_p1 <= id_rs2_data_i;
      r_imm_p1      <= id_imm_i;
      r_pc_p1       <= id_pc_i;
    end
  end

  assign exe_valid_o    = r_vld_p1;
  assign exe_rs1_o      = r_rs1_p1;
  assign exe_rs2_o      = r_rs2_p1;
  assign exe_rd_o       = r_rd_p1;
  assign exe_use_rs2_o  = r_use_rs2_p1;
  assign exe_regwrite_o = r_regwrite_p1;
  assign exe_memread_o  = r_memread_p1;
  assign exe_memwrite_o = r_memwrite_p1;
  assign exe_memtoreg_o = r_memtoreg_p1;
  assign exe_alusrc_o   = r_alusrc_p1;
  assign exe_branch_o   = r_branch_p1;
  assign exe_aluop_o    = r_aluop_p1;
  assign exe_rs1_data_o = r_rs1_data_p1;
  assign exe_rs2_data_o = r_rs2_data_p1;
  assign exe_imm_o      = r_imm_p1;
  assign exe_pc_o       = r_pc_p1;

`ifdef ID_EXE_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_stall_cnt <= '0;
    else if (stall_o)
      r_stall_cnt <= sat_inc(r_stall_cnt);
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_id_exe_hazard_reg.sv
// Scoreboard bench for id_exe_hazard_reg: a reference model pushes the expected EXE
// state per edge, and each scenario task pops and compares after the edge.
module tb_id_exe_hazard_reg;

`ifdef ID_EXE_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        use_rs2, regwrite, memread, memwrite, memtoreg, alusrc, branch;
    logic [1:0]  aluop;
    logic [31:0] rs1_data, rs2_data, imm, pc;
  } id_t;

  typedef struct packed {
    id_t         f;
    logic [31:0] cnt;
  } rec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic flush_i = 1'b0;
  logic id_valid_i, id_use_rs2_i, id_regwrite_i, id_memread_i, id_memwrite_i;
  logic id_memtoreg_i, id_alusrc_i, id_branch_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [1:0] id_aluop_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i;

  logic stall_o, exe_valid_o, exe_use_rs2_o, exe_regwrite_o, exe_memread_o, exe_memwrite_o;
  logic exe_memtoreg_o, exe_alusrc_o, exe_branch_o;
  logic [4:0] exe_rs1_o, exe_rs2_o, exe_rd_o;
  logic [1:0] exe_aluop_o;
  logic [31:0] exe_rs1_data_o, exe_rs2_data_o, exe_imm_o, exe_pc_o, stall_cnt_o;

  id_exe_hazard_reg #(.DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_use_rs2_i(id_use_rs2_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
    .id_memtoreg_i(id_memtoreg_i), .id_alusrc_i(id_alusrc_i),
    .id_branch_i(id_branch_i), .id_aluop_i(id_aluop_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_pc_i(id_pc_i), .flush_i(flush_i),
    .stall_o(stall_o), .exe_valid_o(exe_valid_o),
    .exe_rs1_o(exe_rs1_o), .exe_rs2_o(exe_rs2_o), .exe_rd_o(exe_rd_o),
    .exe_use_rs2_o(exe_use_rs2_o), .exe_regwrite_o(exe_regwrite_o),
    .exe_memread_o(exe_memread_o), .exe_memwrite_o(exe_memwrite_o),
    .exe_memtoreg_o(exe_memtoreg_o), .exe_alusrc_o(exe_alusrc_o),
    .exe_branch_o(exe_branch_o), .exe_aluop_o(exe_aluop_o),
    .exe_rs1_data_o(exe_rs1_data_o), .exe_rs2_data_o(exe_rs2_data_o),
    .exe_imm_o(exe_imm_o), .exe_pc_o(exe_pc_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  rec_t dut_rec;
  assign dut_rec = {exe_valid_o, exe_rs1_o, exe_rs2_o, exe_rd_o, exe_use_rs2_o,
                    exe_regwrite_o, exe_memread_o, exe_memwrite_o, exe_memtoreg_o,
                    exe_alusrc_o, exe_branch_o, exe_aluop_o, exe_rs1_data_o,
                    exe_rs2_data_o, exe_imm_o, exe_pc_o, stall_cnt_o};

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t m = '0;
  rec_t exp_rec;
  logic exp_stall;
  rec_t sb_q[$];

  function automatic id_t mk(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic use2);
    id_t d;
    d.valid    = 1'b1;
    d.rs1      = rs1;
    d.rs2      = rs2;
    d.rd       = rd;
    d.use_rs2  = use2;
    d.regwrite = 1'b1;
    d.memread  = ld;
    d.memwrite = 1'b0;
    d.memtoreg = ld;
    d.alusrc   = ld;
    d.branch   = 1'b0;
    d.aluop    = ld ? 2'd0 : 2'd2;
    d.rs1_data = $urandom;
    d.rs2_data = $urandom;
    d.imm      = $urandom;
    d.pc       = $urandom;
    return d;
  endfunction

  // Drive one cycle of ID inputs and push the EXE state expected after the next edge.
  task automatic apply(input id_t d, input logic fl, input logic rs);
    logic hz;
    rec_t nx;
    {id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs2_i, id_regwrite_i, id_memread_i,
     id_memwrite_i, id_memtoreg_i, id_alusrc_i, id_branch_i, id_aluop_i, id_rs1_data_i,
     id_rs2_data_i, id_imm_i, id_pc_i} = d;
    flush_i = fl;
    rst_i   = rs;
    hz = m.f.valid & m.f.memread & (m.f.rd != 5'd0) & d.valid &
         ((m.f.rd == d.rs1) | (d.use_rs2 & (m.f.rd == d.rs2)));
    exp_stall = hz & ~fl;
    nx = '0;
    if (!rs) begin
      if (!(fl | hz)) nx.f = d;
      nx.cnt = m.cnt;
      if (CNT_EN && exp_stall && m.cnt != 32'hFFFF_FFFF) nx.cnt = m.cnt + 32'd1;
    end
    m = nx;
    sb_q.push_back(nx);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(id_t'({$urandom, $urandom, $urandom, $urandom, $urandom}), 1'b0, 1'b1);
      @(posedge clk_i); #1;
      exp_rec = sb_q.pop_front();
      n_checks++;
      if (dut_rec !== exp_rec) begin
        n_fail++; $display("FAIL reset_state[%0d] got=%h exp=%h", i, dut_rec, exp_rec);
      end
      n_checks++;
      if (stall_o !== 1'b0 || stall_cnt_o !== 32'd0) begin
        n_fail++; $display("FAIL reset_stall_cnt stall=%b cnt=%0d exp stall=0 cnt=0", stall_o, stall_cnt_o);
      end
    end
    rst_i = 1'b0;
  endtask

  task automatic test_load_use_rs1();
    id_t add;
    logic [31:0] c0;
    add = mk(1'b0, 5'd6, 5'd5, 5'd7, 1'b1);
    apply(mk(1'b1, 5'd5, 5'd2, 5'd0, 1'b0), 1'b0, 1'b0);
    #1; n_checks++;
    if (stall_o !== exp_stall) begin n_fail++; $display("FAIL lu_lw_stall got=%b exp=%b", stall_o, exp_stall); end
    @(posedge clk_i); #1;
    exp_rec = sb_q.pop_front(); c0 = exp_rec.cnt;
    n_checks++;
    if (dut_rec !== exp_rec) begin n_fail++; $display("FAIL lu_lw_capture got=%h exp=%h", dut_rec, exp_rec); end
    apply(add, 1'b0, 1'b0);
    #1; n_checks++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%b exp=1", stall_o); end
    @(posedge clk_i); #1;
    exp_rec = sb_q.pop_front();
    n_checks++;
    if (dut_rec !== exp_rec || exe_rd_o !== 5'd0 || exe_regwrite_o !== 1'b0 || exe_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL lu_bubble got=%h exp=%h", dut_rec, exp_rec);
    end
    apply(add, 1'b0, 1'b0);
    #1; n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_stall_release got=%b exp=0", stall_o); end
    @(posedge clk_i); #1;
    exp_rec = sb_q.pop_front();
    n_checks++;
    if (dut_rec !== exp_rec || exe_rs1_o !== 5'd5 || exe_rd_o !== 5'd6) begin
      n_fail++; $display("FAIL lu_add_capture got=%h exp=%h", dut_rec, exp_rec);
    end
    n_checks++;
    if (stall_cnt_o !== (CNT_EN ? c0 + 32'd1 : 32'd0)) begin
      n_fail++; $display("FAIL lu_count got=%0d exp=%0d", stall_cnt_o, CNT_EN ? c0 + 32'd1 : 32'd0);
    end
  endtask

  task automatic test_rs2_gating();
    for (int u = 0; u < 2; u++) begin
      apply(mk(1'b1, 5'd5, 5'd1, 5'd0, 1'b0), 1'b0, 1'b0);
      @(posedge clk_i); #1;
      exp_rec = sb_q.pop_front();
      n_checks++;
      if (dut_rec !== exp_rec) begin n_fail++; $display("FAIL rs2_lw[%0d] got=%h exp=%h", u, dut_rec, exp_rec); end
      apply(mk(1'b0, 5'd8, 5'd1, 5'd5, u[0]), 1'b0, 1'b0);
      #1; n_checks++;
      if (stall_o !== u[0]) begin n_fail++; $display("FAIL rs2_stall[use=%0d] got=%b exp=%b", u, stall_o, u[0]); end
      @(posedge clk_i); #1;
      exp_rec = sb_q.pop_front();
      n_checks++;
      if (dut_rec !== exp_rec) begin n_fail++; $display("FAIL rs2_next[%0d] got=%h exp=%h", u, dut_rec, exp_rec); end
      if (u == 1) begin
        apply(mk(1'b0, 5'd8, 5'd1, 5'd5, 1'b1), 1'b0, 1'b0);
        @(posedge clk_i); #1;
        exp_rec = sb_q.pop_front();
        n_checks++;
        if (dut_rec !== exp_rec) begin n_fail++; $display("FAIL rs2_recapture got=%h exp=%h", dut_rec, exp_rec); end
      end
    end
  endtask

  task automatic test_x0_load();
    apply(mk(1'b1, 5'd0, 5'd3, 5'd0, 1'b0), 1'b0, 1'b0);
    @(posedge clk_i); #1;
    exp_rec = sb_q.pop_front();
    n_checks++;
    if (dut_rec !== exp_rec) begin n_fail++; $display("FAIL x0_lw got=%h exp=%h", dut_rec, exp_rec); end
    apply(mk(1'b0, 5'd9, 5'd0, 5'd0, 1'b1), 1'b0, 1'b0);
    #1; n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL x0_stall got=%b exp=0", stall_o); end
    @(posedge clk_i); #1;
    exp_rec = sb_q.pop_front();
    n_checks++;
    if (dut_rec !== exp_rec || exe_valid_o !== 1'b1 || exe_rd_o !== 5'd9) begin
      n_fail++; $display("FAIL x0_no_bubble got=%h exp=%h", dut_rec, exp_rec);
    end
  endtask

  task automatic test_flush_priority();
    id_t add;
    logic [31:0] c0;
    add = mk(1'b0, 5'd6, 5'd5, 5'd7, 1'b1);
    apply(mk(1'b1, 5'd5, 5'd2, 5'd0, 1'b0), 1'b0, 1'b0);
    @(posedge clk_i); #1;
    exp_rec = sb_q.pop_front(); c0 = exp_rec.cnt;
    apply(add, 1'b1, 1'b0);
    #1; n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
    @(posedge clk_i); #1;
    exp_rec = sb_q.pop_front();
    n_checks++;
    if (dut_rec !== exp_rec || exe_valid_o !== 1'b0 || stall_cnt_o !== (CNT_EN ? c0 : 32'd0)) begin
      n_fail++; $display("FAIL flush_bubble got=%h exp=%h", dut_rec, exp_rec);
    end
    apply(add, 1'b0, 1'b0);
    #1; n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_after_stall got=%b exp=0", stall_o); end
    @(posedge clk_i); #1;
    exp_rec = sb_q.pop_front();
    n_checks++;
    if (dut_rec !== exp_rec) begin n_fail++; $display("FAIL flush_after got=%h exp=%h", dut_rec, exp_rec); end
  endtask

  task automatic test_pass_through();
    for (int i = 3; i <= 5; i++) begin
      apply(mk(1'b0, i[4:0], i[4:0] - 5'd1, i[4:0], 1'b1), 1'b0, 1'b0);
      #1; n_checks++;
      if (stall_o !== 1'b0) begin n_fail++; $display("FAIL pass_stall[rd=%0d] got=%b exp=0", i, stall_o); end
      @(posedge clk_i); #1;
      exp_rec = sb_q.pop_front();
      n_checks++;
      if (dut_rec !== exp_rec || exe_rd_o !== i[4:0] || exe_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL pass_rd[%0d] got=%h exp=%h", i, dut_rec, exp_rec);
      end
    end
  endtask

  task automatic test_back_to_back();
    id_t seq[5];
    logic [4:0] st;
    seq[0] = mk(1'b1, 5'd5, 5'd1, 5'd0, 1'b0);
    seq[1] = mk(1'b1, 5'd6, 5'd5, 5'd0, 1'b0);
    seq[2] = seq[1];
    seq[3] = mk(1'b0, 5'd7, 5'd2, 5'd6, 1'b1);
    seq[4] = seq[3];
    st = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      apply(seq[i], 1'b0, 1'b0);
      #1; n_checks++;
      if (stall_o !== st[i] || stall_o !== exp_stall) begin
        n_fail++; $display("FAIL b2b_stall[%0d] got=%b exp=%b", i, stall_o, st[i]);
      end
      @(posedge clk_i); #1;
      exp_rec = sb_q.pop_front();
      n_checks++;
      if (dut_rec !== exp_rec) begin n_fail++; $display("FAIL b2b_exe[%0d] got=%h exp=%h", i, dut_rec, exp_rec); end
    end
  endtask

  task automatic test_reset_mid_stall();
    id_t add;
    add = mk(1'b0, 5'd6, 5'd5, 5'd7, 1'b1);
    apply(mk(1'b1, 5'd5, 5'd2, 5'd0, 1'b0), 1'b0, 1'b0);
    @(posedge clk_i); #1;
    exp_rec = sb_q.pop_front();
    apply(add, 1'b0, 1'b1);
    #1; n_checks++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_stall got=%b exp=1", stall_o); end
    @(posedge clk_i); #1;
    exp_rec = sb_q.pop_front();
    n_checks++;
    if (dut_rec !== exp_rec || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_clear got=%h stall=%b exp=%h stall=0", dut_rec, stall_o, exp_rec);
    end
    apply(add, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    exp_rec = sb_q.pop_front();
    n_checks++;
    if (dut_rec !== exp_rec) begin n_fail++; $display("FAIL rst_mid_resume got=%h exp=%h", dut_rec, exp_rec); end
  endtask

  initial begin
    @(posedge clk_i); #1;
    test_reset();
    test_load_use_rs1();
    test_rs2_gating();
    test_x0_load();
    test_flush_priority();
    test_pass_through();
    test_back_to_back();
    test_reset_mid_stall();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_exe_hazard_reg.md
# id_exe_hazard_reg

ID/EXE pipeline register with integrated load-use hazard detection for the 5-stage RISC-V pipeline. Each cycle it captures the decoded instruction from ID into the EXE stage, unless a load-use hazard or a branch flush forces a bubble. The registered source/destination indices and RegWrite drive the EXE-stage forwarding logic. The combinational stall output holds the PC and the IF/ID register.

## Interface
- `DATA_W`, default 32: width of the operand, immediate and PC fields.
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `id_valid_i`  in  1: ID holds a real instruction.
- `id_rs1_i`, `id_rs2_i`, `id_rd_i`  in  5 each: register indices.
- `id_use_rs2_i`  in  1: the instruction reads rs2 (R/S/B type).
- `id_regwrite_i`, `id_memread_i`, `id_memwrite_i`, `id_memtoreg_i`, `id_alusrc_i`, `id_branch_i`  in  1 each: decoded controls.
- `id_aluop_i`  in  2: ALU op class.
- `id_rs1_data_i`, `id_rs2_data_i`, `id_imm_i`, `id_pc_i`  in  DATA_W each: operands, immediate and PC.
- `flush_i`  in  1: branch or jump resolved taken in EXE; squash ID.
- `stall_o`  out  1: hold the PC and IF/ID this cycle (combinational).
- `exe_valid_o`  out  1: the EXE slot holds a real instruction.
- `exe_rs1_o`, `exe_rs2_o`, `exe_rd_o`  out  5 each: registered indices.
- `exe_*_o`: registered copies of every control and data input listed above, with matching widths.
- `stall_cnt_o`  out  32: count of load-use bubbles inserted.

## Operation
- Hazard condition, HZ = `exe_valid_o` & `exe_memread_o` & (`exe_rd_o` != 0) & `id_valid_i` & ((`exe_rd_o` == `id_rs1_i`) | (`id_use_rs2_i` & (`exe_rd_o` == `id_rs2_i`))).
- `stall_o` = HZ & ~`flush_i`. Flush has priority: a squashed instruction never stalls.
- Capture rule on each rising edge, in priority order:
  - `rst_i`: all `exe_*` outputs become 0.
  - `flush_i` or HZ: bubble. `exe_valid_o`, all control outputs and all indices become 0. Data fields become 0.
  - Otherwise: every `exe_*` field takes its `id_*` input, and `exe_valid_o` takes `id_valid_i`.
- A bubble must show `exe_rd_o` = 0 and `exe_regwrite_o` = 0, so downstream forwarding never matches it.
- A stall lasts exactly one cycle per load. The cycle after the bubble, `exe_memread_o` = 0, so HZ deasserts. The instruction held in ID then captures normally.
- x0 is never a hazard source, even when the load targets rd = 0.
- Back-to-back loads: a load that enters EXE normally can create a fresh hazard against the next ID instruction.

## Timing
- Data latency: 1 cycle from ID inputs to `exe_*` outputs.
- `stall_o` is purely combinational from the current `exe_*` registers, `id_*` inputs and `flush_i`. It has no registered delay.
- Reset values: every output is 0, including `stall_o`, since `exe_valid_o` = 0.
- Reset mid-stall: `exe_*` clears on that edge, and `stall_o` is 0 from the next cycle.
- `flush_i` and HZ in the same cycle: bubble inserted, `stall_o` = 0, stall counter not incremented.

## Configuration
- Macro `ID_EXE_STALL_CNT_EN`.
- Defined:
  - `stall_cnt_o` is a 32-bit register, reset to 0.
  - It increments on every edge where `stall_o` = 1 and `rst_i` = 0.
  - It saturates at 0xFFFF_FFFF.
- Not defined: `stall_cnt_o` is tied to 0, and no counter flops exist.

## Test plan
- Reset:
  - Stimulus: assert `rst_i` for 2 cycles with random ID inputs.
  - Required: all `exe_*_o` = 0, `stall_o` = 0, `stall_cnt_o` = 0.
- Load-use on rs1:
  - Stimulus: `lw x5` captured, then ID presents `add x6,x5,x7`.
  - Required: `stall_o` = 1 for one cycle, then a bubble with `exe_rd_o` = 0 and `exe_regwrite_o` = 0.
  - Required: the next cycle captures the add with `exe_rs1_o` = 5, and `stall_cnt_o` = 1 (macro on).
- rs2 gating:
  - Stimulus: `lw x5` in EXE, ID has `id_rs2_i` = 5 with `id_use_rs2_i` = 0.
  - Required: `stall_o` = 0.
  - Stimulus: same, with `id_use_rs2_i` = 1.
  - Required: `stall_o` = 1.
- x0 load:
  - Stimulus: `lw x0` in EXE, ID reads x0.
  - Required: `stall_o` = 0, no bubble.
- Flush priority:
  - Stimulus: hazard condition and `flush_i` = 1 together.
  - Required: `stall_o` = 0, bubble captured, counter unchanged.
- Plain pass-through:
  - Stimulus: non-load stream with `id_rd_i` = 3, 4, 5 on consecutive cycles.
  - Required: `exe_rd_o` follows one cycle later, `exe_valid_o` = 1 throughout, no stalls.
